// File: rtl/uart_dbg_pkg.sv
// Shared constants, state encoding and sizing helper for the UART debug bridge.
package uart_dbg_pkg;

  localparam logic [7:0] OP_READ  = 8'h11;
  localparam logic [7:0] OP_WRITE = 8'h12;
  localparam logic [7:0] OP_EXEC  = 8'h13;
  localparam logic [7:0] RSP_ACK  = 8'h06;
  localparam logic [7:0] RSP_EOT  = 8'h04;

  localparam logic [31:0] SOC_CTRL_BASE = 32'h0300_0000;
  localparam logic [31:0] BOOTADDR_OFS  = 32'h0000_0004;
  localparam logic [31:0] FETCHEN_OFS   = 32'h0000_0008;

  localparam int unsigned TIMEOUT_CYCLES_DEF = 1_000_000;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ADDR,
    ST_DATA,
    ST_BUS_REQ,
    ST_BUS_RSP,
    ST_TX_DATA,
    ST_TX_ACK,
    ST_TX_NAK
  } state_e;

  // Inter-byte timeout counter width for a given cycle budget.
  function automatic int unsigned tmo_width(input int unsigned cycles);
    return $clog2(cycles);
  endfunction

endpackage

// File: rtl/uart_dbg_bridge.sv
// UART byte-stream to OBI debug bridge: parses READ/WRITE/EXEC frames, performs
// one 32-bit bus access at a time and streams back data plus ACK/EOT.
module uart_dbg_bridge
  import uart_dbg_pkg::*;
#(
  parameter logic [31:0] BootAddrAddr  = SOC_CTRL_BASE + BOOTADDR_OFS,
  parameter logic [31:0] FetchEnAddr   = SOC_CTRL_BASE + FETCHEN_OFS,
  parameter int unsigned TimeoutCycles = TIMEOUT_CYCLES_DEF
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        rx_valid_i,
  input  logic [7:0]  rx_data_i,
  output logic        rx_ready_o,
  output logic        tx_valid_o,
  output logic [7:0]  tx_data_o,
  input  logic        tx_ready_i,
  output logic        obi_req_o,
  input  logic        obi_gnt_i,
  output logic [31:0] obi_addr_o,
  output logic        obi_we_o,
  output logic [3:0]  obi_be_o,
  output logic [31:0] obi_wdata_o,
  input  logic        obi_rvalid_i,
  input  logic [31:0] obi_rdata_i,
  input  logic        obi_err_i,
  output logic        busy_o
);

  localparam int unsigned   TmoW   = tmo_width(TimeoutCycles);
  localparam logic [TmoW-1:0] TmoMax = TmoW'(TimeoutCycles - 1);

  state_e          state_q, state_d;
  logic [7:0]      op_q, op_d;
  logic [1:0]      cnt_q, cnt_d;
  logic [31:0]     addr_q, addr_d;
  logic [31:0]     wdata_q, wdata_d;
  logic [31:0]     rdata_q, rdata_d;
  logic            phase_q, phase_d;
  logic [TmoW-1:0] tmo_q, tmo_d;
  logic            rx_ready_q, rx_ready_d;
  logic            tx_valid_q, tx_valid_d;
  logic [7:0]      tx_data_q, tx_data_d;
  logic            obi_req_q, obi_req_d;
  logic [31:0]     obi_addr_q, obi_addr_d;
  logic            obi_we_q, obi_we_d;
  logic [31:0]     obi_wdata_q, obi_wdata_d;
  logic            busy_q, busy_d;
  logic            rx_fire, tx_fire;

  // Handshakes are masked during reset so no byte is taken or offered then.
  assign rx_ready_o  = rx_ready_q & ~rst_i;
  assign tx_valid_o  = tx_valid_q & ~rst_i;
  assign tx_data_o   = tx_data_q;
  assign obi_req_o   = obi_req_q;
  assign obi_addr_o  = obi_addr_q;
  assign obi_we_o    = obi_we_q;
  assign obi_be_o    = 4'hF;
  assign obi_wdata_o = obi_wdata_q;
  assign busy_o      = busy_q;

  assign rx_fire = rx_valid_i & rx_ready_o;
  assign tx_fire = tx_valid_o & tx_ready_i;

  always_comb begin
    state_d     = state_q;
    op_d        = op_q;
    cnt_d       = cnt_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    rdata_d     = rdata_q;
    phase_d     = phase_q;
    tmo_d       = tmo_q;
    tx_valid_d  = tx_valid_q;
    tx_data_d   = tx_data_q;
    obi_req_d   = obi_req_q;
    obi_addr_d  = obi_addr_q;
    obi_we_d    = obi_we_q;
    obi_wdata_d = obi_wdata_q;

    unique case (state_q)
      ST_IDLE: begin
        tmo_d   = '0;
        cnt_d   = '0;
        phase_d = 1'b0;
        if (rx_fire) begin
          if (rx_data_i == OP_READ || rx_data_i == OP_WRITE || rx_data_i == OP_EXEC) begin
            op_d    = rx_data_i;
            state_d = ST_ADDR;
          end else begin
            tx_valid_d = 1'b1;
            tx_data_d  = RSP_EOT;
            state_d    = ST_TX_NAK;
          end
        end
      end

      ST_ADDR, ST_DATA: begin
        if (rx_fire) begin
          tmo_d = '0;
          cnt_d = cnt_q + 2'd1;
          if (state_q == ST_ADDR) addr_d  = {rx_data_i, addr_q[31:8]};
          else                    wdata_d = {rx_data_i, wdata_q[31:8]};
          if (cnt_q == 2'd3) begin
            if (state_q == ST_ADDR && op_q == OP_WRITE) begin
              state_d = ST_DATA;
            end else begin
              state_d   = ST_BUS_REQ;
              obi_req_d = 1'b1;
              if (op_q == OP_EXEC) begin
                obi_addr_d  = BootAddrAddr;
                obi_we_d    = 1'b1;
                obi_wdata_d = addr_d;
              end else begin
                obi_addr_d  = {addr_d[31:2], 2'b00};
                obi_we_d    = (op_q == OP_WRITE);
                obi_wdata_d = (op_q == OP_WRITE) ? wdata_d : 32'h0;
              end
            end
          end
        end else if (tmo_q == TmoMax) begin
          // Host went quiet mid-frame: drop the partial frame without a reply.
          tmo_d   = '0;
          cnt_d   = '0;
          state_d = ST_IDLE;
        end else begin
          tmo_d = tmo_q + TmoW'(1);
        end
      end

      ST_BUS_REQ: begin
        if (obi_req_q && obi_gnt_i) begin
          obi_req_d = 1'b0;
          state_d   = ST_BUS_RSP;
        end
      end

      ST_BUS_RSP: begin
        if (obi_rvalid_i) begin
          if (obi_err_i) begin
            tx_valid_d = 1'b1;
            tx_data_d  = RSP_EOT;
            state_d    = ST_TX_NAK;
          end else if (op_q == OP_READ) begin
            rdata_d    = obi_rdata_i;
            tx_valid_d = 1'b1;
            tx_data_d  = obi_rdata_i[7:0];
            cnt_d      = '0;
            state_d    = ST_TX_DATA;
          end else if (op_q == OP_EXEC && !phase_q) begin
            phase_d     = 1'b1;
            obi_req_d   = 1'b1;
            obi_addr_d  = FetchEnAddr;
            obi_we_d    = 1'b1;
            obi_wdata_d = 32'h1;
            state_d     = ST_BUS_REQ;
          end else begin
            tx_valid_d = 1'b1;
            tx_data_d  = RSP_ACK;
            state_d    = ST_TX_ACK;
          end
        end
      end

      ST_TX_DATA: begin
        if (tx_fire) begin
          if (cnt_q == 2'd3) begin
            tx_data_d = RSP_ACK;
            state_d   = ST_TX_ACK;
          end else begin
            cnt_d     = cnt_q + 2'd1;
            tx_data_d = rdata_q[{cnt_d, 3'b000} +: 8];
          end
        end
      end

      ST_TX_ACK, ST_TX_NAK: begin
        if (tx_fire) begin
          tx_valid_d = 1'b0;
          state_d    = ST_IDLE;
        end
      end

      default: state_d = ST_IDLE;
    endcase

    rx_ready_d = (state_d == ST_IDLE) || (state_d == ST_ADDR) || (state_d == ST_DATA);
    busy_d     = (state_d != ST_IDLE);
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= ST_IDLE;
      op_q        <= '0;
      cnt_q       <= '0;
      addr_q      <= '0;
      wdata_q     <= '0;
      rdata_q     <= '0;
      phase_q     <= 1'b0;
      tmo_q       <= '0;
      rx_ready_q  <= 1'b0;
      tx_valid_q  <= 1'b0;
      tx_data_q   <= '0;
      obi_req_q   <= 1'b0;
      obi_addr_q  <= '0;
      obi_we_q    <= 1'b0;
      obi_wdata_q <= '0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      op_q        <= op_d;
      cnt_q       <= cnt_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      rdata_q     <= rdata_d;
      phase_q     <= phase_d;
      tmo_q       <= tmo_d;
      rx_ready_q  <= rx_ready_d;
      tx_valid_q  <= tx_valid_d;
      tx_data_q   <= tx_data_d;
      obi_req_q   <= obi_req_d;
      obi_addr_q  <= obi_addr_d;
      obi_we_q    <= obi_we_d;
      obi_wdata_q <= obi_wdata_d;
      busy_q      <= busy_d;
    end
  end

endmodule
